// File: rtl/i2c_target_rw.sv
// I2C target serving write and read transfers on one 7-bit address.
// SCL/SDA are oversampled on CLK; SDA is driven open-drain (low or released).
module i2c_target_rw #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] TX_DATA,
    output logic       TX_TAKEN,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SH,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;
    logic [7:0]             rx_byte_s;

    state_t     state_r, state_nxt;
    logic [3:0] cnt_r, cnt_nxt;
    logic [6:0] shift_r, shift_nxt;
    logic [6:0] tx_sh_r, tx_sh_nxt;
    logic       sda_low_r, sda_low_nxt;
    logic       rw_r, rw_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt;
    logic       tx_taken_nxt;
    logic       busy_nxt;

    // Reset releases the line immediately, without waiting for a clock edge.
    assign SDA = (sda_low_r && !RST) ? 1'b0 : 1'bz;

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign rx_byte_s  = {shift_r, sda_s};

    // Input synchronizers and one-flop edge history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], SCL};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], SDA};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            shift_r   <= 7'd0;
            tx_sh_r   <= 7'd0;
            sda_low_r <= 1'b0;
            rw_r      <= 1'b0;
            RX_DATA   <= 8'd0;
            RX_VALID  <= 1'b0;
            TX_TAKEN  <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            shift_r   <= shift_nxt;
            tx_sh_r   <= tx_sh_nxt;
            sda_low_r <= sda_low_nxt;
            rw_r      <= rw_nxt;
            RX_DATA   <= rx_data_nxt;
            RX_VALID  <= rx_valid_nxt;
            TX_TAKEN  <= tx_taken_nxt;
            BUSY      <= busy_nxt;
        end
    end

    // Next-state logic: STOP beats START beats bit activity.
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        shift_nxt    = shift_r;
        tx_sh_nxt    = tx_sh_r;
        sda_low_nxt  = sda_low_r;
        rw_nxt       = rw_r;
        rx_data_nxt  = RX_DATA;
        rx_valid_nxt = 1'b0;
        tx_taken_nxt = 1'b0;
        busy_nxt     = BUSY;

        if (stop_s) begin
            state_nxt   = IDLE;
            cnt_nxt     = 4'd0;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else if (start_s) begin
            state_nxt   = ADDR_SH;
            cnt_nxt     = 4'd0;
            sda_low_nxt = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_low_nxt = 1'b0;
                end
                ADDR_SH: begin
                    if (scl_rise_s) begin
                        shift_nxt = rx_byte_s[6:0];
                        if (cnt_r == 4'd7) begin
                            cnt_nxt = 4'd0;
                            rw_nxt  = sda_s;
                            if (rx_byte_s[7:1] == ADDR) begin
                                state_nxt = ADDR_ACK;
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end else begin
                            cnt_nxt = cnt_r + 4'd1;
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                // cnt 0: waiting for the end of the R/W bit; cnt 1: inside the ACK clock.
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (cnt_r == 4'd0) begin
                            sda_low_nxt = 1'b1;
                            busy_nxt    = 1'b1;
                            cnt_nxt     = 4'd1;
                        end else begin
                            cnt_nxt = 4'd0;
                            if (rw_r) begin
                                tx_sh_nxt    = TX_DATA[6:0];
                                tx_taken_nxt = 1'b1;
                                sda_low_nxt  = ~TX_DATA[7];
                                state_nxt    = TX_BYTE;
                            end else begin
                                sda_low_nxt = 1'b0;
                                state_nxt   = RX_BYTE;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                RX_BYTE: begin
                    if (scl_rise_s) begin
                        shift_nxt = rx_byte_s[6:0];
                        if (cnt_r == 4'd7) begin
                            rx_data_nxt  = rx_byte_s;
                            rx_valid_nxt = 1'b1;
                            cnt_nxt      = 4'd0;
                            state_nxt    = RX_ACK;
                        end else begin
                            cnt_nxt = cnt_r + 4'd1;
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                RX_ACK: begin
                    if (scl_fall_s) begin
                        if (cnt_r == 4'd0) begin
                            sda_low_nxt = 1'b1;
                            cnt_nxt     = 4'd1;
                        end else begin
                            sda_low_nxt = 1'b0;
                            cnt_nxt     = 4'd0;
                            state_nxt   = RX_BYTE;
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall_s) begin
                        if (cnt_r == 4'd7) begin
                            sda_low_nxt = 1'b0;
                            cnt_nxt     = 4'd0;
                            state_nxt   = TX_ACK;
                        end else begin
                            tx_sh_nxt   = {tx_sh_r[5:0], 1'b0};
                            sda_low_nxt = ~tx_sh_r[6];
                            cnt_nxt     = cnt_r + 4'd1;
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                // cnt 1 records that the controller acknowledged the byte.
                TX_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_s) begin
                            sda_low_nxt = 1'b0;
                            cnt_nxt     = 4'd0;
                            state_nxt   = WAIT_STOP;
                        end else begin
                            cnt_nxt = 4'd1;
                        end
                    end else if (scl_fall_s && (cnt_r == 4'd1)) begin
                        tx_sh_nxt    = TX_DATA[6:0];
                        tx_taken_nxt = 1'b1;
                        sda_low_nxt  = ~TX_DATA[7];
                        cnt_nxt      = 4'd0;
                        state_nxt    = TX_BYTE;
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                WAIT_STOP: begin
                    sda_low_nxt = 1'b0;
                end
                default: begin
                    state_nxt   = IDLE;
                    cnt_nxt     = 4'd0;
                    sda_low_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_rw.sv
// Bench for i2c_target_rw: a bit-banged I2C controller on a pulled-up SDA line,
// a table of write transfers, and hand-written read / repeated-START / reset sequences.
module tb_i2c_target_rw;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       ctl_low;
    logic [7:0] tx_data;
    logic       tx_taken;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    wire        sda_bus;

    assign sda_bus = ctl_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target_rw #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .CLK      (clk),
        .RST      (rst),
        .SCL      (scl),
        .SDA      (sda_bus),
        .TX_DATA  (tx_data),
        .TX_TAKEN (tx_taken),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .BUSY     (busy)
    );

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
    } wr_vec_t;

    int         tests = 0;
    int         fails = 0;
    int         rx_pulses = 0;
    int         tx_pulses = 0;
    int         exp_rx_pulses = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic quarter();
        repeat (10) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctl_low = 1'b0;
        quarter();
        scl = 1'b1;
        quarter();
        ctl_low = 1'b1;
        quarter();
        scl = 1'b0;
        quarter();
    endtask

    task automatic i2c_stop();
        ctl_low = 1'b1;
        quarter();
        scl = 1'b1;
        quarter();
        ctl_low = 1'b0;
        quarter();
        quarter();
    endtask

    task automatic bit_xfer(input logic b, output logic sampled);
        ctl_low = ~b;
        quarter();
        scl = 1'b1;
        quarter();
        sampled = sda_bus;
        quarter();
        scl = 1'b0;
        quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_bits(output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
    endtask

    wr_vec_t    tbl[6];
    logic       ack;
    logic       s;
    logic [7:0] b;
    logic [7:0] exp_b;
    int         tx_before;

    initial begin
        tbl[0] = '{addr: 7'h42, data: 8'hA5, exp_ack: 1'b1};
        tbl[1] = '{addr: 7'h42, data: 8'h00, exp_ack: 1'b1};
        tbl[2] = '{addr: 7'h42, data: 8'hFF, exp_ack: 1'b1};
        tbl[3] = '{addr: 7'h43, data: 8'hFF, exp_ack: 1'b0};
        tbl[4] = '{addr: 7'h21, data: 8'h5A, exp_ack: 1'b0};
        tbl[5] = '{addr: 7'h42, data: 8'h81, exp_ack: 1'b1};

        rst     = 1'b1;
        scl     = 1'b1;
        ctl_low = 1'b0;
        tx_data = 8'h00;

        fork
            begin
                repeat (90000) @(posedge clk);
                $display("FAIL watchdog: cycle budget exhausted");
                $fatal(1);
            end
            begin
                logic rx_prev = 1'b0;
                logic tx_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rx_valid) begin
                        rx_pulses++;
                        check("rx_valid_width", {31'd0, rx_prev}, 32'd0);
                        if (rx_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL rx_unexpected: got 0x%0h, expected no RX_VALID", rx_data);
                        end else begin
                            exp_b = rx_q.pop_front();
                            check("rx_scoreboard", {24'd0, rx_data}, {24'd0, exp_b});
                        end
                    end
                    if (tx_taken) begin
                        tx_pulses++;
                        check("tx_taken_width", {31'd0, tx_prev}, 32'd0);
                    end
                    rx_prev = rx_valid;
                    tx_prev = tx_taken;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_sda", {31'd0, sda_bus}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_taken", {31'd0, tx_taken}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        quarter();

        // Table of single-byte writes, matching and mismatching addresses.
        for (int i = 0; i < 6; i++) begin
            i2c_start();
            send_byte({tbl[i].addr, 1'b0}, ack);
            check("wr_addr_ack", {31'd0, ack}, {31'd0, tbl[i].exp_ack});
            check("wr_busy_after_addr", {31'd0, busy}, {31'd0, tbl[i].exp_ack});
            if (tbl[i].exp_ack) begin
                rx_q.push_back(tbl[i].data);
                exp_rx_pulses++;
            end
            send_byte(tbl[i].data, ack);
            check("wr_data_ack", {31'd0, ack}, {31'd0, tbl[i].exp_ack});
            i2c_stop();
            check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        end
        check("wr_last_rx_data", {24'd0, rx_data}, 32'h81);

        // Single-byte read terminated by NACK.
        tx_before = tx_pulses;
        tx_data = 8'h3C;
        tx_q.push_back(8'h3C);
        i2c_start();
        send_byte(8'h85, ack);
        check("rd1_addr_ack", {31'd0, ack}, 32'd1);
        recv_bits(b);
        exp_b = tx_q.pop_front();
        check("rd1_byte", {24'd0, b}, {24'd0, exp_b});
        bit_xfer(1'b1, s);
        check("rd1_sda_released_at_ack", {31'd0, s}, 32'd1);
        check("rd1_busy_wait_stop", {31'd0, busy}, 32'd1);
        bit_xfer(1'b1, s);
        check("rd1_idle_bit_released", {31'd0, s}, 32'd1);
        i2c_stop();
        check("rd1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("rd1_tx_taken_count", tx_pulses - tx_before, 32'd1);

        // Two-byte read: ACK after the first byte, NACK after the second.
        tx_before = tx_pulses;
        tx_data = 8'h11;
        tx_q.push_back(8'h11);
        i2c_start();
        send_byte(8'h85, ack);
        check("rd2_addr_ack", {31'd0, ack}, 32'd1);
        recv_bits(b);
        exp_b = tx_q.pop_front();
        check("rd2_byte0", {24'd0, b}, {24'd0, exp_b});
        tx_data = 8'hEE;
        tx_q.push_back(8'hEE);
        bit_xfer(1'b0, s);
        recv_bits(b);
        exp_b = tx_q.pop_front();
        check("rd2_byte1", {24'd0, b}, {24'd0, exp_b});
        bit_xfer(1'b1, s);
        check("rd2_sda_released_at_nack", {31'd0, s}, 32'd1);
        i2c_stop();
        check("rd2_tx_taken_count", tx_pulses - tx_before, 32'd2);

        // Write, repeated START, read with no STOP between.
        tx_before = tx_pulses;
        i2c_start();
        send_byte(8'h84, ack);
        check("rs_wr_addr_ack", {31'd0, ack}, 32'd1);
        rx_q.push_back(8'h5A);
        exp_rx_pulses++;
        send_byte(8'h5A, ack);
        check("rs_wr_data_ack", {31'd0, ack}, 32'd1);
        check("rs_rx_data", {24'd0, rx_data}, 32'h5A);
        tx_data = 8'hC3;
        tx_q.push_back(8'hC3);
        i2c_start();
        check("rs_busy_held", {31'd0, busy}, 32'd1);
        send_byte(8'h85, ack);
        check("rs_rd_addr_ack", {31'd0, ack}, 32'd1);
        recv_bits(b);
        exp_b = tx_q.pop_front();
        check("rs_rd_byte", {24'd0, b}, {24'd0, exp_b});
        bit_xfer(1'b1, s);
        i2c_stop();
        check("rs_tx_taken_count", tx_pulses - tx_before, 32'd1);

        // Reset while the target is driving a 0 data bit.
        tx_before = tx_pulses;
        tx_data = 8'h00;
        i2c_start();
        send_byte(8'h85, ack);
        check("rr_addr_ack", {31'd0, ack}, 32'd1);
        check("rr_driving_low", {31'd0, sda_bus}, 32'd0);
        check("rr_tx_taken_count", tx_pulses - tx_before, 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rr_sda_released", {31'd0, sda_bus}, 32'd1);
        check("rr_rx_data", {24'd0, rx_data}, 32'd0);
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rr_tx_taken", {31'd0, tx_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quarter();
        i2c_start();
        send_byte(8'h84, ack);
        check("rr_post_addr_ack", {31'd0, ack}, 32'd1);
        check("rr_post_busy", {31'd0, busy}, 32'd1);
        rx_q.push_back(8'h3F);
        exp_rx_pulses++;
        send_byte(8'h3F, ack);
        check("rr_post_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("rr_post_busy_stop", {31'd0, busy}, 32'd0);

        quarter();
        check("rx_pulse_total", rx_pulses, exp_rx_pulses);
        check("rx_queue_drained", rx_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
